// File: rtl/adf_multi_cfg_if.sv
// rtl/adf_multi_cfg_if.sv - control inputs and per-channel SPI pins for adf_multi_cfg
interface adf_multi_cfg_if #(
   parameter int NUM_CH = 2
);
   logic                 start;
   logic                 retune;
   logic [NUM_CH-1:0]    ch_mask;
   logic [32*NUM_CH-1:0] reg0_data;
   logic [NUM_CH-1:0]    d_clk;
   logic [NUM_CH-1:0]    d_out;
   logic [NUM_CH-1:0]    d_le;
   logic                 ref_clk;
   logic                 busy;
   logic                 cfg_done;
   logic                 wr_done;

   modport master (
      output start, retune, ch_mask, reg0_data,
      input  d_clk, d_out, d_le, ref_clk, busy, cfg_done, wr_done
   );

   modport slave (
      input  start, retune, ch_mask, reg0_data,
      output d_clk, d_out, d_le, ref_clk, busy, cfg_done, wr_done
   );
endinterface

// File: rtl/adf_multi_cfg.sv
// rtl/adf_multi_cfg.sv - lockstep R5..R0 init and per-channel R0 retune for ADF4351 synthesizers
module adf_multi_cfg #(
   parameter int          NUM_CH    = 2,
   parameter int          CLK_DIV   = 2,
   parameter int          LE_CYCLES = 2,
   parameter logic [31:0] REG1      = 32'h0800E1A9,
   parameter logic [31:0] REG2      = 32'h00004E42,
   parameter logic [31:0] REG3      = 32'h000004B3,
   parameter logic [31:0] REG4      = 32'h00AC803C,
   parameter logic [31:0] REG5      = 32'h00400005
) (
   input  logic           clk_i,
   input  logic           rst_i,
   adf_multi_cfg_if.slave bus
);
   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam int LW = $clog2(LE_CYCLES) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [LW-1:0] LE_LAST  = LW'(LE_CYCLES - 1);

   localparam logic [2:0] SEQ_IDLE  = 3'd0;
   localparam logic [2:0] SEQ_LOAD  = 3'd1;
   localparam logic [2:0] SEQ_SHIFT = 3'd2;
   localparam logic [2:0] SEQ_LE    = 3'd3;
   localparam logic [2:0] SEQ_GAP   = 3'd4;
   localparam logic [2:0] SEQ_READY = 3'd5;

   logic [2:0]              state_q, state_d;
   logic [DW-1:0]           div_q, div_d;
   logic [LW-1:0]           le_q, le_d;
   logic [4:0]              bit_q, bit_d;
   logic                    phase_q, phase_d;
   logic [2:0]              idx_q, idx_d;
   logic                    init_q, init_d;
   logic                    fin_q, fin_d;
   logic                    cfg_q, cfg_d;
   logic                    ref_q;
   logic                    wr_q;
   logic [NUM_CH-1:0]       mask_q, mask_d;
   logic [NUM_CH-1:0]       dclk_q, dclk_d;
   logic [NUM_CH-1:0]       dout_q, dout_d;
   logic [NUM_CH-1:0]       dle_q, dle_d;
   logic [NUM_CH-1:0][31:0] sreg_q, sreg_d;
   logic [NUM_CH-1:0][31:0] word;

   // idx_q is the register address; its value always overrides the low three image bits
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         case (idx_q)
            3'd1:    word[i] = REG1;
            3'd2:    word[i] = REG2;
            3'd3:    word[i] = REG3;
            3'd4:    word[i] = REG4;
            3'd5:    word[i] = REG5;
            default: word[i] = bus.reg0_data[32*i +: 32];
         endcase
         word[i][2:0] = idx_q;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      le_d    = le_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      init_d  = init_q;
      fin_d   = 1'b0;
      cfg_d   = cfg_q | fin_q;
      mask_d  = mask_q;
      sreg_d  = sreg_q;
      dclk_d  = dclk_q;
      dout_d  = dout_q;
      dle_d   = dle_q;
      case (state_q)
         SEQ_IDLE: begin
            state_d = SEQ_LOAD;
            init_d  = 1'b1;
            idx_d   = 3'd5;
            cfg_d   = 1'b0;
         end
         SEQ_LOAD: begin
            mask_d  = init_q ? {NUM_CH{1'b1}} : bus.ch_mask;
            for (int i = 0; i < NUM_CH; i++) begin
               sreg_d[i] = {word[i][30:0], 1'b0};
               dout_d[i] = word[i][31] & mask_d[i];
            end
            dclk_d  = '0;
            div_d   = '0;
            phase_d = 1'b0;
            bit_d   = '0;
            state_d = SEQ_SHIFT;
         end
         SEQ_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
                  dclk_d  = mask_q;
               end else begin
                  phase_d = 1'b0;
                  dclk_d  = '0;
                  if (bit_q == 5'd31) begin
                     bit_d   = '0;
                     dout_d  = '0;
                     dle_d   = mask_q;
                     le_d    = '0;
                     state_d = SEQ_LE;
                  end else begin
                     bit_d = bit_q + 5'd1;
                     for (int i = 0; i < NUM_CH; i++) begin
                        dout_d[i] = sreg_q[i][31] & mask_q[i];
                        sreg_d[i] = {sreg_q[i][30:0], 1'b0};
                     end
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SEQ_LE: begin
            if (le_q == LE_LAST) begin
               dle_d   = '0;
               state_d = SEQ_GAP;
            end else begin
               le_d = le_q + 1'b1;
            end
         end
         SEQ_GAP: begin
            if (init_q && idx_q != 3'd0) begin
               idx_d   = idx_q - 3'd1;
               state_d = SEQ_LOAD;
            end else begin
               fin_d   = init_q;
               init_d  = 1'b0;
               state_d = SEQ_READY;
            end
         end
         SEQ_READY: begin
            // START has priority; a retune with an empty mask never leaves READY
            if (bus.start) begin
               state_d = SEQ_LOAD;
               init_d  = 1'b1;
               idx_d   = 3'd5;
               cfg_d   = 1'b0;
            end else if (bus.retune && |bus.ch_mask) begin
               state_d = SEQ_LOAD;
               init_d  = 1'b0;
               idx_d   = 3'd0;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SEQ_IDLE;
         div_q   <= '0;
         le_q    <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         idx_q   <= '0;
         init_q  <= 1'b0;
         fin_q   <= 1'b0;
         cfg_q   <= 1'b0;
         ref_q   <= 1'b0;
         wr_q    <= 1'b0;
         mask_q  <= '0;
         dclk_q  <= '0;
         dout_q  <= '0;
         dle_q   <= '0;
         sreg_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         le_q    <= le_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         init_q  <= init_d;
         fin_q   <= fin_d;
         cfg_q   <= cfg_d;
         ref_q   <= ~ref_q;
         wr_q    <= (state_q == SEQ_GAP);
         mask_q  <= mask_d;
         dclk_q  <= dclk_d;
         dout_q  <= dout_d;
         dle_q   <= dle_d;
         sreg_q  <= sreg_d;
      end
   end

   assign bus.d_clk    = dclk_q;
   assign bus.d_out    = dout_q;
   assign bus.d_le     = dle_q;
   assign bus.ref_clk  = ref_q;
   assign bus.cfg_done = cfg_q;
   assign bus.wr_done  = wr_q;
   assign bus.busy     = (state_q == SEQ_LOAD) || (state_q == SEQ_SHIFT) ||
                         (state_q == SEQ_LE)   || (state_q == SEQ_GAP);
endmodule

// File: tb/tb_adf_multi_cfg.sv
// tb/tb_adf_multi_cfg.sv - self-checking bench for adf_multi_cfg with default parameters
module tb_adf_multi_cfg;
   localparam int NC = 2;
   localparam int WP = 132;

   logic clk = 1'b0;
   logic rst = 1'b1;
   adf_multi_cfg_if #(.NUM_CH(NC)) bus();
   adf_multi_cfg #(.NUM_CH(NC)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int wr_cnt = 0;

   bit [31:0] cap_q [NC][$];
   bit [31:0] exp_q [NC][$];
   bit [31:0] sh [NC];
   int        nb [NC];
   logic [NC-1:0] pclk = '0;
   logic [NC-1:0] ple  = '0;

   typedef struct {
      logic [1:0]  mask;
      logic [31:0] d0, d1;
      int          n0;
      logic [31:0] w0;
      int          n1;
      logic [31:0] w1;
      int          busy_cyc;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] img(int n, logic [31:0] r0);
      case (n)
         5: return 32'h00400005;
         4: return 32'h00AC803C;
         3: return 32'h000004B3;
         2: return 32'h00004E42;
         1: return 32'h0800E1A9;
         default: return {r0[31:3], 3'b000};
      endcase
   endfunction

   task automatic push_init(logic [32*NC-1:0] r0);
      for (int c = 0; c < NC; c++)
         for (int n = 5; n >= 0; n--) exp_q[c].push_back(img(n, r0[32*c +: 32]));
   endtask

   task automatic cmp_words(string tag);
      for (int c = 0; c < NC; c++) begin
         chk({tag, "_count"}, cap_q[c].size(), exp_q[c].size());
         for (int j = 0; j < exp_q[c].size() && j < cap_q[c].size(); j++)
            chk({tag, "_word"}, cap_q[c][j], exp_q[c][j]);
         cap_q[c].delete();
         exp_q[c].delete();
      end
   endtask

   // Reassemble each channel's serial word from D_OUT sampled at D_CLK rising edges
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < NC; i++) nb[i] = 0;
         pclk = '0;
         ple  = '0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            if (bus.d_clk[i] && !pclk[i]) begin
               sh[i] = {sh[i][30:0], bus.d_out[i]};
               nb[i]++;
            end
            if (bus.d_le[i] && !ple[i]) begin
               chk("le_after_32_bits", nb[i], 32);
               cap_q[i].push_back(sh[i]);
               nb[i] = 0;
            end
         end
         if (bus.wr_done) wr_cnt++;
         pclk = bus.d_clk;
         ple  = bus.d_le;
      end
   end

   // A full init was launched at the coming edge (reset release or START); follow it
   task automatic run_full(string tag, int poke);
      int   first;
      int   bcnt;
      logic prev, nref;
      first  = -1;
      bcnt   = 0;
      wr_cnt = 0;
      prev   = bus.ref_clk;
      for (int k = 0; k < 900; k++) begin
         @(posedge clk);
         @(negedge clk);
         bus.start  = 1'b0;
         bus.retune = 1'b0;
         if (k == 0) chk({tag, "_cfg_low"}, bus.cfg_done, 1'b0);
         if (k < 4) begin
            nref = ~prev;
            chk({tag, "_ref_toggle"}, bus.ref_clk, nref);
         end
         prev = bus.ref_clk;
         if (bus.busy) bcnt++;
         if (bus.cfg_done && first < 0) first = k;
         if (k == poke) begin
            bus.start   = 1'b1;
            bus.retune  = 1'b1;
            bus.ch_mask = 2'b11;
         end
      end
      chk({tag, "_cfg_cycle"}, first, 6 * WP + 1);
      chk({tag, "_busy_cycles"}, bcnt, 6 * WP);
      chk({tag, "_wr_done"}, wr_cnt, 6);
   endtask

   initial begin
      tbl[0] = '{2'b01, 32'h00501F40, 32'h00500000, 1, 32'h00501F40, 0, 32'h0, WP};
      tbl[1] = '{2'b01, 32'h00501F47, 32'h00500000, 1, 32'h00501F40, 0, 32'h0, WP};
      tbl[2] = '{2'b10, 32'h00000000, 32'h12345677, 0, 32'h0, 1, 32'h12345670, WP};
      tbl[3] = '{2'b11, 32'hFFFFFFFF, 32'h8000000F, 1, 32'hFFFFFFF8, 1, 32'h80000008, WP};
      tbl[4] = '{2'b00, 32'hAAAAAAAA, 32'h55555555, 0, 32'h0, 0, 32'h0, 0};

      bus.start     = 1'b0;
      bus.retune    = 1'b0;
      bus.ch_mask   = '0;
      bus.reg0_data = {32'h00500000, 32'h00501F47};

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_d_clk", bus.d_clk, 2'b00);
      chk("rst_d_out", bus.d_out, 2'b00);
      chk("rst_d_le", bus.d_le, 2'b00);
      chk("rst_ref_clk", bus.ref_clk, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_cfg_done", bus.cfg_done, 1'b0);
      chk("rst_wr_done", bus.wr_done, 1'b0);

      // automatic init after release
      rst = 1'b0;
      push_init(bus.reg0_data);
      run_full("init", -1);
      cmp_words("init");

      // table of retunes issued from READY
      for (int v = 0; v < 5; v++) begin
         int bcnt;
         bcnt = 0;
         wr_cnt = 0;
         bus.reg0_data = {tbl[v].d1, tbl[v].d0};
         bus.ch_mask   = tbl[v].mask;
         bus.retune    = 1'b1;
         if (tbl[v].n0 > 0) exp_q[0].push_back(tbl[v].w0);
         if (tbl[v].n1 > 0) exp_q[1].push_back(tbl[v].w1);
         for (int k = 0; k < 140; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) bus.retune = 1'b0;
            if (k == 1) begin
               bus.reg0_data = ~bus.reg0_data;
               bus.ch_mask   = ~bus.ch_mask;
            end
            if (bus.busy) bcnt++;
         end
         chk("tbl_busy_cycles", bcnt, tbl[v].busy_cyc);
         chk("tbl_wr_done", wr_cnt, (tbl[v].n0 + tbl[v].n1 > 0) ? 1 : 0);
         cmp_words("tbl");
      end

      // START and RETUNE together in READY
      bus.reg0_data = {32'h01234567, 32'h089ABCDE};
      bus.ch_mask   = 2'b01;
      bus.start     = 1'b1;
      bus.retune    = 1'b1;
      push_init(bus.reg0_data);
      run_full("start_wins", -1);
      cmp_words("start_wins");

      // START with START/RETUNE re-pulsed mid-init
      bus.start = 1'b1;
      push_init(bus.reg0_data);
      run_full("busy_ignore", 300);
      cmp_words("busy_ignore");

      // reset in the middle of R3, bit 15
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 327; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_d_clk", bus.d_clk, 2'b00);
      chk("abort_d_out", bus.d_out, 2'b00);
      chk("abort_d_le", bus.d_le, 2'b00);
      chk("abort_ref_clk", bus.ref_clk, 1'b0);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_wr_done", bus.wr_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < NC; c++) begin
         exp_q[c].push_back(img(5, 32'h0));
         exp_q[c].push_back(img(4, 32'h0));
      end
      push_init(bus.reg0_data);
      run_full("restart", -1);
      cmp_words("restart");

      // randomized traffic against a timing/word model
      begin : rnd
         int  blo, bhi, rdy, cfg_rise, lock, exp_wr;
         bit  st, rt;
         blo = 1; bhi = 0; rdy = 0; cfg_rise = -1000; lock = -1; exp_wr = 0;
         wr_cnt = 0;
         for (int t = 0; t < 8000; t++) begin
            chk("rnd_busy", bus.busy, (t - 1 >= blo) && (t - 1 <= bhi));
            chk("rnd_cfg_done", bus.cfg_done, (t - 1 >= cfg_rise));
            if (t > lock) begin
               bus.reg0_data = {$urandom, $urandom};
               bus.ch_mask   = 2'($urandom);
            end
            st = (t < 7100) && ($urandom_range(0, 199) == 0);
            rt = (t < 7100) && ($urandom_range(0, 19) == 0);
            bus.start  = st;
            bus.retune = rt;
            if (t >= rdy && st) begin
               push_init(bus.reg0_data);
               blo = t; bhi = t + 6 * WP - 1; rdy = t + 6 * WP + 1;
               cfg_rise = t + 6 * WP + 1; lock = t + 5 * WP + 1; exp_wr += 6;
            end else if (t >= rdy && rt && bus.ch_mask != 2'b00) begin
               for (int c = 0; c < NC; c++)
                  if (bus.ch_mask[c]) exp_q[c].push_back(img(0, bus.reg0_data[32*c +: 32]));
               blo = t; bhi = t + WP - 1; rdy = t + WP + 1; lock = t + 1; exp_wr += 1;
            end
            @(posedge clk);
            @(negedge clk);
            bus.start  = 1'b0;
            bus.retune = 1'b0;
         end
         chk("rnd_wr_done", wr_cnt, exp_wr);
         cmp_words("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adf_multi_cfg.md
ADF_MULTI_CFG -- requirements
Module: adf_multi_cfg

Interface
REQ-001 Parameter NUM_CH, default 2, number of ADF4351 synthesizers driven in lockstep (1..8).
REQ-002 Parameter CLK_DIV, default 2, CLK cycles per D_CLK half-period (>=1).
REQ-003 Parameter LE_CYCLES, default 2, CLK cycles D_LE is held high after each word (>=1).
REQ-004 Parameters REG1..REG5, defaults 32'h0800E1A9, 32'h00004E42, 32'h000004B3, 32'h00AC803C, 32'h00400005, common register images.
REQ-005 CLK  input  1  system clock; all logic on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 START  input  1  single-cycle pulse, rerun full R5..R0 init on all channels.
REQ-008 RETUNE  input  1  single-cycle pulse, write R0 only to channels in CH_MASK.
REQ-009 CH_MASK  input  NUM_CH  retune channel select, bit i = channel i.
REQ-010 REG0_DATA  input  32*NUM_CH  per-channel R0 image, channel i at bits [32i+31:32i].
REQ-011 D_CLK / D_OUT / D_LE  output  NUM_CH each  per-channel SPI clock, data, latch enable.
REQ-012 REF_CLK  output  1  CLK/2 reference, toggles every cycle out of reset.
REQ-013 BUSY  output  1  high while any word is being shifted or latched.
REQ-014 CFG_DONE  output  1  high once full init has completed; cleared by reset or START.
REQ-015 WR_DONE  output  1  one-cycle pulse at end of each word (after gap cycle).

Function
REQ-016 Controller FSM states SEQ_IDLE, SEQ_LOAD, SEQ_SHIFT, SEQ_LE, SEQ_GAP, SEQ_READY.
REQ-017 After reset release: SEQ_IDLE for one cycle, then automatic full init without START.
REQ-018 Full init word order: R5, R4, R3, R2, R1, R0, on all channels; R0 per channel from REG0_DATA.
REQ-019 Retune: single R0 word, only channels with CH_MASK bit set; others keep D_CLK/D_OUT/D_LE low.
REQ-020 Every word bits[2:0] forced to register address (R0=000 ... R5=101) regardless of parameter/input value.
REQ-021 REG0_DATA and CH_MASK sampled in SEQ_LOAD; later changes do not affect the word in flight.
REQ-022 Shift MSB first; D_OUT updates at start of D_CLK low phase; D_CLK low CLK_DIV cycles, then high CLK_DIV cycles, per bit.
REQ-023 SEQ_SHIFT lasts exactly 64*CLK_DIV cycles; D_CLK ends low; D_LE high LE_CYCLES cycles; SEQ_GAP one cycle all low.
REQ-024 Word period (LOAD to next LOAD) = 64*CLK_DIV + LE_CYCLES + 2 cycles; default 132.
REQ-025 BUSY high from SEQ_LOAD through SEQ_GAP inclusive; low in SEQ_READY.
REQ-026 CFG_DONE rises in cycle after R0 WR_DONE of full init; stays high through retunes.
REQ-027 In SEQ_READY: START and RETUNE same cycle -> START wins, RETUNE dropped.
REQ-028 START/RETUNE while BUSY ignored, not queued.
REQ-029 RETUNE with CH_MASK all zero ignored; no BUSY, no WR_DONE.
REQ-030 Bit counter 5 bits, wraps 31->0 only on transition to SEQ_LE; divider counter width $clog2(CLK_DIV)+1.

Reset
REQ-031 RST high at any edge, including mid-word: FSM SEQ_IDLE, counters 0, all D_CLK/D_OUT/D_LE 0, REF_CLK 0, BUSY 0, CFG_DONE 0, WR_DONE 0.
REQ-032 Partially shifted word aborted without D_LE pulse; full init restarts after release.

Verification
REQ-033 Reset release, defaults, NUM_CH=2 -> six words per channel in order 00400005,00AC803C,000004B3,00004E42,0800E1A9,REG0; CFG_DONE high at cycle 6*132+1.
REQ-034 REG0_DATA ch0=00501F40, ch1=00500000, RETUNE with CH_MASK=2'b01 in READY -> ch0 shifts 00501F40 (132 cycles), ch1 pins stay low, one WR_DONE.
REQ-035 REG0_DATA ch0=00501F47 -> shifted word 00501F40 (address bits forced).
REQ-036 RST asserted at bit 15 of R3 -> outputs 0 next cycle, no D_LE, restart from R5, CFG_DONE low until new init completes.
REQ-037 START and RETUNE same cycle in READY -> full six-word init, CFG_DONE low during, no separate R0-only write.
REQ-038 RETUNE during init, and RETUNE with CH_MASK=0 in READY -> ignored; word count and timing unchanged, BUSY stays low in latter.
